// File: rtl/psum_axis_pkg.sv
// ----------------------------------------------------------------------------
// psum_axis_pkg
// Shared definitions for the psum AXI-Stream packer:
//   - psum_state_e   : streaming FSM state encoding (IDLE / STREAM)
//   - LANES_PER_WORD : psums packed per output beat (4)
//   - LANE_WIDTH     : bits per output lane (8)
//   - calc_beats()   : beats needed to send one psum vector
// ----------------------------------------------------------------------------
package psum_axis_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } psum_state_e;

    localparam int LANES_PER_WORD = 4;
    localparam int LANE_WIDTH     = 8;

    // One beat carries LANES_PER_WORD consecutive psums.
    function automatic int calc_beats(input int mac_num);
        return mac_num / LANES_PER_WORD;
    endfunction

endpackage

// File: rtl/psum_pingpong_buf.sv
// ----------------------------------------------------------------------------
// psum_pingpong_buf
// Two-entry ping-pong buffer holding whole psum vectors.
// A push is accepted only while fewer than two entries are occupied; a push
// into a full buffer is dropped and raises the sticky overflow flag, even if
// the head entry is popped in the same cycle.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_push       : vector offered this cycle
//   i_data       : vector to store
//   i_pop        : release the head entry
//   i_ovf_clear  : clear the overflow flag (a same-cycle drop wins)
//   o_head       : head (read) entry
//   o_next_lo    : low LO_W bits of the entry behind the head
//   o_occ        : current occupancy (0..2)
//   o_push_acc   : the offered push is accepted this cycle
//   o_full       : registered, both entries occupied
//   o_overflow   : registered sticky drop flag
// ----------------------------------------------------------------------------
module psum_pingpong_buf
    import psum_axis_pkg::*;
#(
    parameter int DATA_W = 1280,
    parameter int LO_W   = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    input  logic              i_ovf_clear,
    output logic [DATA_W-1:0] o_head,
    output logic [LO_W-1:0]   o_next_lo,
    output logic [1:0]        o_occ,
    output logic              o_push_acc,
    output logic              o_full,
    output logic              o_overflow
);

    logic [DATA_W-1:0] r_mem [0:1];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_occ;
    logic              r_full;
    logic              r_overflow;

    logic              w_push_acc;
    logic              w_drop;
    logic              w_pop;
    logic [1:0]        w_occ_nxt;

    // Qualify push/pop against the current occupancy and compute the next one.
    always_comb begin
        w_push_acc = i_push && (r_occ != 2'd2);
        w_drop     = i_push && (r_occ == 2'd2);
        w_pop      = i_pop && (r_occ != 2'd0);
        case ({w_push_acc, w_pop})
            2'b10:   w_occ_nxt = r_occ + 2'd1;
            2'b01:   w_occ_nxt = r_occ - 2'd1;
            default: w_occ_nxt = r_occ;
        endcase
    end

    // Entry storage, pointers, occupancy, full and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0]   <= {DATA_W{1'b0}};
            r_mem[1]   <= {DATA_W{1'b0}};
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_occ      <= 2'd0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ  <= w_occ_nxt;
            r_full <= (w_occ_nxt == 2'd2);
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_ovf_clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_head     = r_mem[r_rd_ptr];
    assign o_next_lo  = r_mem[~r_rd_ptr][LO_W-1:0];
    assign o_occ      = r_occ;
    assign o_push_acc = w_push_acc;
    assign o_full     = r_full;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/psum_axis_packer.sv
// ----------------------------------------------------------------------------
// psum_axis_packer
// Buffers psum vectors from the MAC array in a 2-entry ping-pong buffer and
// streams each one as MAC_NUM/4 AXI-Stream beats; lane k of beat b carries
// psum 4b+k widened to 8 bits. TLAST closes a packet of vectors_per_packet
// vectors (0 counts as 1), sampled when the first vector of a packet loads.
//
// Optional feature: define PSUM_RELU_EN to clamp negative psums to zero
// before packing; otherwise psums are sign-extended (PSUM_WIDTH must be < 8).
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   psum_in, psum_valid  : input vector and its strobe (no backpressure)
//   vectors_per_packet   : vectors per AXIS packet
//   overflow_clear       : clears psum_overflow
//   M_AXIS_*             : AXI-Stream master (TVALID/TDATA/TSTRB/TLAST/TREADY)
//   psum_buf_full        : both buffer entries occupied
//   psum_overflow        : sticky, a vector was dropped
// ----------------------------------------------------------------------------
module psum_axis_packer
    import psum_axis_pkg::*;
#(
    parameter int MAC_NUM              = 256,
    parameter int PSUM_WIDTH           = 5,
    parameter int C_M_AXIS_TDATA_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [PSUM_WIDTH*MAC_NUM-1:0]     psum_in,
    input  logic                              psum_valid,
    input  logic [11:0]                       vectors_per_packet,
    input  logic                              overflow_clear,
    output logic                              M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic                              M_AXIS_TLAST,
    input  logic                              M_AXIS_TREADY,
    output logic                              psum_buf_full,
    output logic                              psum_overflow
);

    localparam int VEC_W  = PSUM_WIDTH * MAC_NUM;
    localparam int GRP_W  = LANES_PER_WORD * PSUM_WIDTH;
    localparam int WORD_W = LANES_PER_WORD * LANE_WIDTH;
    localparam int BEATS  = calc_beats(MAC_NUM);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    // Widen one group of LANES_PER_WORD psums into an output word.
    function automatic logic [WORD_W-1:0] pack_beat(input logic [GRP_W-1:0] grp);
        logic [WORD_W-1:0]     word;
        logic [PSUM_WIDTH-1:0] p;
        word = {WORD_W{1'b0}};
        for (int k = 0; k < LANES_PER_WORD; k++) begin
            p = grp[k*PSUM_WIDTH +: PSUM_WIDTH];
`ifdef PSUM_RELU_EN
            if (p[PSUM_WIDTH-1]) begin
                word[k*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{1'b0}};
            end else begin
                word[k*LANE_WIDTH +: LANE_WIDTH] = {{(LANE_WIDTH-PSUM_WIDTH){1'b0}}, p};
            end
`else
            word[k*LANE_WIDTH +: LANE_WIDTH] = {{(LANE_WIDTH-PSUM_WIDTH){p[PSUM_WIDTH-1]}}, p};
`endif
        end
        return word;
    endfunction

    psum_state_e                   r_state;
    logic                          r_tvalid;
    logic                          r_tlast;
    logic [WORD_W-1:0]             r_tdata;
    logic [BEAT_W-1:0]             r_beat;
    logic [11:0]                   r_vec;
    logic [11:0]                   r_len;

    logic [VEC_W-1:0]              w_head;
    logic [BEATS-1:0][GRP_W-1:0]   w_head_beats;
    logic [GRP_W-1:0]              w_next_lo;
    logic [1:0]                    w_occ;
    logic                          w_push_acc;
    logic                          w_full;
    logic                          w_overflow;

    logic                          w_hs;
    logic                          w_last_hs;
    logic [BEAT_W-1:0]             w_beat_inc;
    logic [11:0]                   w_vec_after;
    logic [11:0]                   w_len_fresh;
    logic                          w_new_avail;
    logic                          w_load_new;
    logic [11:0]                   w_new_vec;
    logic [11:0]                   w_new_len;
    logic [GRP_W-1:0]              w_new_grp;
    logic [WORD_W-1:0]             w_new_word;
    logic                          w_new_tlast;
    logic [WORD_W-1:0]             w_cont_word;
    logic                          w_cont_tlast;

    psum_pingpong_buf #(
        .DATA_W (VEC_W),
        .LO_W   (GRP_W)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (psum_valid),
        .i_data      (psum_in),
        .i_pop       (w_last_hs),
        .i_ovf_clear (overflow_clear),
        .o_head      (w_head),
        .o_next_lo   (w_next_lo),
        .o_occ       (w_occ),
        .o_push_acc  (w_push_acc),
        .o_full      (w_full),
        .o_overflow  (w_overflow)
    );

    assign w_head_beats = w_head;

    // Next-beat candidates: continuing the current vector or starting a new one.
    // A new vector is taken from the buffer when it is already stored there, or
    // straight from psum_in when it is being captured on this very edge, which
    // gives TVALID one cycle after psum_valid and no bubble between vectors.
    always_comb begin
        w_hs        = r_tvalid && M_AXIS_TREADY;
        w_last_hs   = w_hs && (r_beat == LAST_BEAT);
        w_beat_inc  = r_beat + BEAT_W'(1);
        w_vec_after = r_tlast ? 12'd0 : (r_vec + 12'd1);
        w_len_fresh = (vectors_per_packet == 12'd0) ? 12'd1 : vectors_per_packet;

        if (r_state == ST_IDLE) begin
            w_new_avail = (w_occ != 2'd0) || w_push_acc;
            w_new_vec   = r_vec;
            w_new_grp   = (w_occ != 2'd0) ? w_head_beats[0] : psum_in[GRP_W-1:0];
            w_load_new  = w_new_avail;
        end else begin
            // The head is being popped, so a second stored entry comes first.
            w_new_avail = (w_occ == 2'd2) || w_push_acc;
            w_new_vec   = w_vec_after;
            w_new_grp   = (w_occ == 2'd2) ? w_next_lo : psum_in[GRP_W-1:0];
            w_load_new  = w_last_hs && w_new_avail;
        end

        // The packet length is taken fresh only when vector 0 of a packet loads.
        w_new_len    = (w_new_vec == 12'd0) ? w_len_fresh : r_len;
        w_new_word   = pack_beat(w_new_grp);
        w_new_tlast  = (LAST_BEAT == {BEAT_W{1'b0}}) && (w_new_vec == (w_new_len - 12'd1));
        w_cont_word  = pack_beat(w_head_beats[w_beat_inc]);
        w_cont_tlast = (w_beat_inc == LAST_BEAT) && (r_vec == (r_len - 12'd1));
    end

    // Streaming FSM with registered AXIS outputs, beat and vector counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= {WORD_W{1'b0}};
            r_beat   <= {BEAT_W{1'b0}};
            r_vec    <= 12'd0;
            r_len    <= 12'd1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_new_avail) begin
                        r_state <= ST_STREAM;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (w_last_hs) begin
                        r_vec <= w_vec_after;
                        if (w_new_avail) begin
                            r_state <= ST_STREAM;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_state <= ST_STREAM;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_load_new) begin
                r_tvalid <= 1'b1;
                r_beat   <= {BEAT_W{1'b0}};
                r_tdata  <= w_new_word;
                r_tlast  <= w_new_tlast;
                if (w_new_vec == 12'd0) begin
                    r_len <= w_len_fresh;
                end
            end else if (w_last_hs) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
                r_beat   <= {BEAT_W{1'b0}};
            end else if (w_hs) begin
                r_beat   <= w_beat_inc;
                r_tdata  <= w_cont_word;
                r_tlast  <= w_cont_tlast;
            end
        end
    end

    assign M_AXIS_TVALID = r_tvalid;
    assign M_AXIS_TDATA  = r_tdata;
    assign M_AXIS_TLAST  = r_tlast;
    assign M_AXIS_TSTRB  = {(C_M_AXIS_TDATA_WIDTH/8){1'b1}};
    assign psum_buf_full = w_full;
    assign psum_overflow = w_overflow;

endmodule

// File: tb/tb_psum_axis_packer.sv
// ----------------------------------------------------------------------------
// tb_psum_axis_packer
// Self-checking bench for psum_axis_packer. A queue-based reference model
// tracks stored vectors, the beat being presented and packet position, and
// every cycle predicts TVALID/TDATA/TLAST/psum_buf_full/psum_overflow.
// Define PSUM_RELU_EN for both bench and RTL to check the clamping build.
// ----------------------------------------------------------------------------
module tb_psum_axis_packer;

    localparam int MAC_NUM = 256;
    localparam int PW      = 5;
    localparam int BEATS   = MAC_NUM / 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [PW*MAC_NUM-1:0]   psum_in;
    logic                    psum_valid;
    logic [11:0]             vectors_per_packet;
    logic                    overflow_clear;
    logic                    tvalid;
    logic [31:0]             tdata;
    logic [3:0]              tstrb;
    logic                    tlast;
    logic                    tready;
    logic                    buf_full;
    logic                    overflow;

    always #5 clk = ~clk;

    psum_axis_packer #(
        .MAC_NUM              (MAC_NUM),
        .PSUM_WIDTH           (PW),
        .C_M_AXIS_TDATA_WIDTH (32)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .psum_in            (psum_in),
        .psum_valid         (psum_valid),
        .vectors_per_packet (vectors_per_packet),
        .overflow_clear     (overflow_clear),
        .M_AXIS_TVALID      (tvalid),
        .M_AXIS_TDATA       (tdata),
        .M_AXIS_TSTRB       (tstrb),
        .M_AXIS_TLAST       (tlast),
        .M_AXIS_TREADY      (tready),
        .psum_buf_full      (buf_full),
        .psum_overflow      (overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int store [0:7][0:MAC_NUM-1];
    int q[$];
    int next_id;
    int head_beat;
    int vec_in_pkt;
    int pkt_len;
    bit len_valid;
    bit m_ovf;
    int hs_count;
    int tlast_count;
    int cur_vals [0:MAC_NUM-1];

    typedef struct {
        logic [4:0]  val;
        logic [31:0] exp_plain;
        logic [31:0] exp_relu;
    } vec_rec_t;
    vec_rec_t tbl [0:4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beat: lane k of beat b is psum 4b+k as an 8-bit two's complement value.
    function automatic logic [31:0] exp_word(input int id, input int b);
        logic [31:0] w;
        int v;
        w = 32'h0;
        for (int k = 0; k < 4; k++) begin
            v = store[id][4*b+k];
`ifdef PSUM_RELU_EN
            if (v < 0) v = 0;
`endif
            w[8*k +: 8] = v[7:0];
        end
        return w;
    endfunction

    task automatic model_reset();
        q.delete();
        head_beat  = 0;
        vec_in_pkt = 0;
        pkt_len    = 1;
        len_valid  = 1'b0;
        m_ovf      = 1'b0;
    endtask

    task automatic set_psum();
        int t;
        for (int i = 0; i < MAC_NUM; i++) begin
            t = cur_vals[i];
            psum_in[i*PW +: PW] = t[PW-1:0];
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < MAC_NUM; i++) cur_vals[i] = int'($urandom_range(0, 31)) - 16;
        set_psum();
    endtask

    // Called at posedge+1 with inputs applied: check outputs, advance model, step one clock.
    task automatic tick();
        bit exp_v, exp_last, hs, pop, ovf_evt;
        int id;
        #4;
        exp_v    = (q.size() > 0);
        exp_last = exp_v && (head_beat == BEATS-1) && (vec_in_pkt == pkt_len-1);
        chk("tvalid", {31'h0, tvalid}, {31'h0, exp_v});
        if (exp_v) begin
            chk("tdata", tdata, exp_word(q[0], head_beat));
            chk("tlast", {31'h0, tlast}, {31'h0, exp_last});
        end
        chk("buf_full", {31'h0, buf_full}, {31'h0, (q.size() == 2)});
        chk("overflow", {31'h0, overflow}, {31'h0, m_ovf});

        hs      = exp_v && tready;
        pop     = hs && (head_beat == BEATS-1);
        ovf_evt = 1'b0;
        if (psum_valid) begin
            if (q.size() < 2) begin
                id      = next_id;
                next_id = (next_id + 1) % 8;
                for (int i = 0; i < MAC_NUM; i++) store[id][i] = cur_vals[i];
                q.push_back(id);
            end else begin
                ovf_evt = 1'b1;
            end
        end
        if (ovf_evt) m_ovf = 1'b1;
        else if (overflow_clear) m_ovf = 1'b0;
        if (hs) begin
            hs_count++;
            if (exp_last) tlast_count++;
            if (pop) begin
                void'(q.pop_front());
                head_beat = 0;
                if (exp_last) begin
                    vec_in_pkt = 0;
                    len_valid  = 1'b0;
                end else begin
                    vec_in_pkt++;
                end
            end else begin
                head_beat++;
            end
        end
        if ((q.size() > 0) && (vec_in_pkt == 0) && !len_valid) begin
            pkt_len   = (vectors_per_packet == 12'd0) ? 1 : int'(vectors_per_packet);
            len_valid = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec();
        set_psum();
        psum_valid = 1'b1;
        tick();
        psum_valid = 1'b0;
    endtask

    task automatic drain(input bit rand_ready);
        for (int n = 0; (n < 3000) && (q.size() > 0); n++) begin
            tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            tick();
        end
        chk("drain_empty", q.size(), 32'd0);
        tready = 1'b1;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, {31'h0, tvalid}, 32'd0);
        chk({tag, "_tlast"}, {31'h0, tlast}, 32'd0);
        chk({tag, "_tdata"}, tdata, 32'h0);
        chk({tag, "_full"}, {31'h0, buf_full}, 32'd0);
        chk({tag, "_ovf"}, {31'h0, overflow}, 32'd0);
        chk({tag, "_tstrb"}, {28'h0, tstrb}, 32'hF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0, tl0;
        tbl[0] = '{5'h10, 32'hF0F0F0F0, 32'h00000000};
        tbl[1] = '{5'h0F, 32'h0F0F0F0F, 32'h0F0F0F0F};
        tbl[2] = '{5'h1F, 32'hFFFFFFFF, 32'h00000000};
        tbl[3] = '{5'h01, 32'h01010101, 32'h01010101};
        tbl[4] = '{5'h18, 32'hF8F8F8F8, 32'h00000000};

        rst_n = 1'b0; psum_in = '0; psum_valid = 1'b0; vectors_per_packet = 12'd1;
        overflow_clear = 1'b0; tready = 1'b0;
        next_id = 0; hs_count = 0; tlast_count = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Constant-fill vectors: beat 0 against the table, all beats against the model.
        tready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < MAC_NUM; i++) cur_vals[i] = int'($signed(tbl[r].val));
            push_vec();
            #2;
`ifdef PSUM_RELU_EN
            chk("table_beat0", tdata, tbl[r].exp_relu);
`else
            chk("table_beat0", tdata, tbl[r].exp_plain);
`endif
            drain(1'b0);
        end

        // Ramp vector, single-vector packets.
        for (int i = 0; i < MAC_NUM; i++) cur_vals[i] = i % 16;
        hs0 = hs_count; tl0 = tlast_count;
        push_vec();
        #2;
        chk("ramp_tvalid", {31'h0, tvalid}, 32'd1);
        chk("ramp_beat0", tdata, 32'h03020100);
        drain(1'b0);
        chk("ramp_beats", hs_count - hs0, BEATS);
        chk("ramp_tlasts", tlast_count - tl0, 32'd1);

        // Three-vector packet with random TREADY and a mid-packet length change.
        vectors_per_packet = 12'd3;
        hs0 = hs_count; tl0 = tlast_count;
        tready = 1'b1;
        fill_rand(); push_vec();
        fill_rand(); push_vec();
        vectors_per_packet = 12'd7;
        for (int n = 0; (n < 500) && (q.size() >= 2); n++) begin
            tready = ($urandom_range(0, 1) == 1);
            tick();
        end
        fill_rand(); push_vec();
        drain(1'b1);
        chk("pkt3_beats", hs_count - hs0, 3*BEATS);
        chk("pkt3_tlasts", tlast_count - tl0, 32'd1);

        // Fill and overflow with the sink stalled.
        vectors_per_packet = 12'd1;
        tready = 1'b0;
        fill_rand(); push_vec();
        fill_rand(); push_vec();
        #2;
        chk("full_after_two", {31'h0, buf_full}, 32'd1);
        fill_rand(); push_vec();
        #2;
        chk("ovf_after_three", {31'h0, overflow}, 32'd1);
        hs0 = hs_count;
        drain(1'b0);
        chk("ovf_streamed", hs_count - hs0, 2*BEATS);
        overflow_clear = 1'b1; tick(); overflow_clear = 1'b0;
        #2;
        chk("ovf_cleared", {31'h0, overflow}, 32'd0);
        tready = 1'b0;
        fill_rand(); push_vec();
        fill_rand(); push_vec();
        fill_rand(); set_psum();
        psum_valid = 1'b1; overflow_clear = 1'b1; tick();
        psum_valid = 1'b0; overflow_clear = 1'b0;
        #2;
        chk("ovf_beats_clear", {31'h0, overflow}, 32'd1);
        drain(1'b0);
        overflow_clear = 1'b1; tick(); overflow_clear = 1'b0;

        // Asynchronous reset at beat 20 of the first vector of a 2-vector packet.
        vectors_per_packet = 12'd2;
        tready = 1'b1;
        fill_rand(); push_vec();
        for (int n = 0; (n < 100) && (head_beat < 20); n++) tick();
        chk("reached_beat20", head_beat, 32'd20);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vectors_per_packet = 12'd1;
        hs0 = hs_count; tl0 = tlast_count;
        fill_rand(); push_vec();
        drain(1'b0);
        chk("post_reset_beats", hs_count - hs0, BEATS);
        chk("post_reset_tlasts", tlast_count - tl0, 32'd1);

        // Zero packet length behaves as one vector per packet.
        vectors_per_packet = 12'd0;
        tl0 = tlast_count;
        fill_rand(); push_vec();
        fill_rand(); push_vec();
        drain(1'b0);
        chk("vpp0_tlasts", tlast_count - tl0, 32'd2);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if ((c % 97) == 0) vectors_per_packet = 12'($urandom_range(0, 3));
            psum_valid = ($urandom_range(0, 59) == 0);
            if (psum_valid) fill_rand();
            overflow_clear = ($urandom_range(0, 49) == 0);
            tready = ($urandom_range(0, 3) != 0);
            tick();
        end
        psum_valid = 1'b0;
        overflow_clear = 1'b0;
        drain(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
